seq_matrix_multiplier: RTL and testbench

//  Computes R = A x B for square M x M matrices of 32-bit signed integers, one multiply-accumulate at a time.

---
 rtl/seq_matrix_multiplier_pkg.sv | 19 +
 rtl/seq_matrix_multiplier_if.sv | 31 +++
 rtl/seq_matrix_multiplier_mac.sv | 16 +
 rtl/seq_matrix_multiplier.sv | 105 ++++++++++
 tb/tb_seq_matrix_multiplier.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_matrix_multiplier_pkg.sv
// Shared types and constants for the sequential matrix multiplier.
package seq_mm_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALC,
        WRITE,
        DONE
    } state_t;

    // Index width for an M x M matrix, never narrower than one bit.
    function automatic int idx_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seq_matrix_multiplier_if.sv
// Operand-read, result-write and control signals of the multiplier.
interface seq_mm_if import seq_mm_pkg::*; #(parameter int M = 4);

    localparam int IDX_W = idx_width(M);

    logic              start;
    logic              done;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [DATA_W-1:0] current_element;
    logic              z_ack;
    logic              z_stb;
    logic [DATA_W-1:0] z_out;
    logic [IDX_W-1:0]  a_i;
    logic [IDX_W-1:0]  a_j;
    logic [IDX_W-1:0]  b_i;
    logic [IDX_W-1:0]  b_j;
    logic [IDX_W-1:0]  z_i;
    logic [IDX_W-1:0]  z_j;

    modport master (
        input  start, a_in, b_in, current_element, z_ack,
        output done, z_stb, z_out, a_i, a_j, b_i, b_j, z_i, z_j
    );

    modport slave (
        output start, a_in, b_in, current_element, z_ack,
        input  done, z_stb, z_out, a_i, a_j, b_i, b_j, z_i, z_j
    );

endinterface

// File: rtl/seq_matrix_multiplier_mac.sv
// Combinational multiply-accumulate; the first term of a dot product ignores acc.
module seq_mm_mac import seq_mm_pkg::*; (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] acc,
    input  logic              first,
    output logic [DATA_W-1:0] result
);

    logic signed [DATA_W-1:0] prod;

    // Only the low DATA_W bits are kept, so signed and unsigned products agree.
    assign prod   = $signed(a) * $signed(b);
    assign result = first ? prod : acc + prod;

endmodule

// File: rtl/seq_matrix_multiplier.sv
// R = A x B over M x M matrices, one MAC per handshake, partial sums written back to R.
module seq_matrix_multiplier import seq_mm_pkg::*; #(
    parameter int M = 4
) (
    input  logic     clk,
    input  logic     rst,
    seq_mm_if.master bus
);

    localparam int               IDX_W = idx_width(M);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(M - 1);

    state_t            state;
    logic [IDX_W-1:0]  i;
    logic [IDX_W-1:0]  j;
    logic [IDX_W-1:0]  k;
    logic [DATA_W-1:0] z_reg;
    logic [DATA_W-1:0] mac_result;
    logic              stb_reg;
    logic              done_reg;

    seq_mm_mac u_mac (
        .a      (bus.a_in),
        .b      (bus.b_in),
        .acc    (bus.current_element),
        .first  (k == '0),
        .result (mac_result)
    );

    // Loop order i (outer), j, k (inner); the consumer's ack is honoured only in WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            z_reg    <= '0;
            stb_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state <= CALC;
                end
                CALC: begin
                    z_reg   <= mac_result;
                    stb_reg <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (bus.z_ack) begin
                        stb_reg <= 1'b0;
                        if (k == LAST) begin
                            k <= '0;
                            if (j == LAST) begin
                                j <= '0;
                                i <= i + 1'b1;
                            end else begin
                                j <= j + 1'b1;
                            end
                        end else begin
                            k <= k + 1'b1;
                        end
                        if (i == LAST && j == LAST && k == LAST) begin
                            done_reg <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    stb_reg <= 1'b0;
                    // A held-high start must drop before another product can begin.
                    if (!bus.start) begin
                        done_reg <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_i   = i;
    assign bus.a_j   = k;
    assign bus.b_i   = k;
    assign bus.b_j   = j;
    assign bus.z_i   = i;
    assign bus.z_j   = j;
    assign bus.z_out = z_reg;
    assign bus.z_stb = stb_reg;
    assign bus.done  = done_reg;

endmodule

// File: tb/tb_seq_matrix_multiplier.sv
// Self-checking bench: operand/result memories and a reference product live here.
module tb_seq_matrix_multiplier;

    localparam int M     = 4;
    localparam int IDX_W = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] mat_a [M][M];
    logic [31:0] mat_b [M][M];
    logic [31:0] mat_r [M][M];
    logic [31:0] ref_r [M][M];

    seq_mm_if #(.M(M)) bus ();

    seq_matrix_multiplier #(.M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.a_in            = mat_a[bus.a_i][bus.a_j];
    assign bus.b_in            = mat_b[bus.b_i][bus.b_j];
    assign bus.current_element = mat_r[bus.z_i][bus.z_j];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running dot-product sum of row ii and column jj up to term kk, mod 2^32.
    function automatic logic [31:0] partial_sum(input int ii, input int jj, input int kk);
        logic [31:0] s;
        s = 32'd0;
        for (int t = 0; t <= kk; t++) s = s + mat_a[ii][t] * mat_b[t][jj];
        return s;
    endfunction

    task automatic compute_reference();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++)
                ref_r[r][c] = partial_sum(r, c, M - 1);
    endtask

    task automatic check_result_matrix(input string name);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                checks++;
                if (mat_r[r][c] !== ref_r[r][c]) begin
                    errors++;
                    $display("[TB] FAIL %s R[%0d][%0d]: got %h expected %h", name, r, c, mat_r[r][c], ref_r[r][c]);
                end
            end
    endtask

    task automatic clear_result();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) mat_r[r][c] = $urandom;
    endtask

    // Runs one product acting as the consumer; stop_at >= 0 returns with that write still pending.
    task automatic apply_stimulus(input int min_delay, input int max_delay, input bit long_ack, input int stop_at);
        int          ii, jj, kk, d, waited;
        logic [31:0] exp_z, cap_z;
        @(negedge clk);
        bus.start = 1'b1;
        for (int w = 0; w < M * M * M; w++) begin
            ii = w / (M * M);
            jj = (w / M) % M;
            kk = w % M;
            waited = 0;
            while (bus.z_stb !== 1'b1 && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (bus.z_stb !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stb_timeout write %0d: z_stb=%b expected 1", w, bus.z_stb);
                return;
            end
            exp_z = partial_sum(ii, jj, kk);
            cap_z = bus.z_out;
            checks++;
            if (bus.z_out !== exp_z) begin
                errors++;
                $display("[TB] FAIL z_out write %0d (%0d,%0d,%0d): got %h expected %h", w, ii, jj, kk, bus.z_out, exp_z);
            end
            checks++;
            if (bus.z_i !== IDX_W'(ii) || bus.z_j !== IDX_W'(jj) || bus.a_i !== IDX_W'(ii) ||
                bus.a_j !== IDX_W'(kk) || bus.b_i !== IDX_W'(kk) || bus.b_j !== IDX_W'(jj)) begin
                errors++;
                $display("[TB] FAIL addr write %0d: z=(%0d,%0d) a=(%0d,%0d) b=(%0d,%0d) expected i=%0d j=%0d k=%0d",
                         w, bus.z_i, bus.z_j, bus.a_i, bus.a_j, bus.b_i, bus.b_j, ii, jj, kk);
            end
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL early_done write %0d: done=%b expected 0", w, bus.done);
            end
            if (w == stop_at) return;
            d = $urandom_range(max_delay, min_delay);
            repeat (d) begin
                @(negedge clk);
                checks++;
                if (bus.z_stb !== 1'b1 || bus.z_out !== cap_z || bus.z_i !== IDX_W'(ii) || bus.z_j !== IDX_W'(jj) ||
                    bus.a_j !== IDX_W'(kk) || bus.b_i !== IDX_W'(kk)) begin
                    errors++;
                    $display("[TB] FAIL hold write %0d: stb=%b z_out=%h z=(%0d,%0d) k=%0d expected stb=1 z_out=%h z=(%0d,%0d) k=%0d",
                             w, bus.z_stb, bus.z_out, bus.z_i, bus.z_j, bus.a_j, cap_z, ii, jj, kk);
                end
            end
            bus.z_ack = 1'b1;
            @(negedge clk);
            mat_r[ii][jj] = cap_z;
            if (long_ack) @(negedge clk);
            bus.z_ack = 1'b0;
            checks++;
            if (bus.z_stb !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stb_clear write %0d: z_stb=%b expected 0", w, bus.z_stb);
            end
        end
        checks++;
        if (bus.done !== 1'b1 || bus.z_stb !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_rise: done=%b z_stb=%b expected 1/0", bus.done, bus.z_stb);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b1 || bus.z_stb !== 1'b0) begin
                errors++;
                $display("[TB] FAIL done_hold: done=%b z_stb=%b expected 1/0", bus.done, bus.z_stb);
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_clear: done=%b expected 0", bus.done);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.z_out !== 32'd0 || bus.z_stb !== 1'b0 || bus.done !== 1'b0 || bus.z_i !== '0 || bus.z_j !== '0 ||
            bus.a_i !== '0 || bus.a_j !== '0 || bus.b_i !== '0 || bus.b_j !== '0) begin
            errors++;
            $display("[TB] FAIL %s: z_out=%h stb=%b done=%b z=(%0d,%0d) a=(%0d,%0d) b=(%0d,%0d) expected all 0",
                     name, bus.z_out, bus.z_stb, bus.done, bus.z_i, bus.z_j, bus.a_i, bus.a_j, bus.b_i, bus.b_j);
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                mat_a[r][c] = $urandom;
                mat_b[r][c] = $urandom;
            end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.z_ack = 1'b0;
        fill_random();
        clear_result();
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_identity();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                mat_a[r][c] = (r == c) ? 32'd1 : 32'd0;
                mat_b[r][c] = 32'(4 * r + c);
                ref_r[r][c] = 32'(4 * r + c);
            end
        clear_result();
        apply_stimulus(1, 1, 1'b0, -1);
        check_result_matrix("identity");
    endtask

    task automatic test_constant();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                mat_a[r][c] = 32'd2;
                mat_b[r][c] = 32'd3;
                ref_r[r][c] = 32'd24;
            end
        clear_result();
        apply_stimulus(1, 2, 1'b0, -1);
        check_result_matrix("constant");
    endtask

    task automatic test_signed();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                mat_a[r][c] = 32'd0;
                mat_b[r][c] = 32'd0;
                ref_r[r][c] = 32'd0;
            end
        mat_a[0][0] = -32'sd5;
        mat_b[0][0] = 32'd7;
        mat_a[1][1] = 32'h0001_0000;
        mat_b[1][1] = 32'h0001_0000;
        ref_r[0][0] = 32'hFFFF_FFDD;
        clear_result();
        apply_stimulus(1, 3, 1'b0, -1);
        check_result_matrix("signed_overflow");
    endtask

    task automatic test_ack_hold();
        fill_random();
        compute_reference();
        clear_result();
        apply_stimulus(5, 5, 1'b0, -1);
        check_result_matrix("ack_hold");
    endtask

    task automatic test_reset_midrun();
        fill_random();
        clear_result();
        apply_stimulus(1, 2, 1'b0, 1 * M * M + 2 * M);
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        check_idle_outputs("reset_async");
        @(negedge clk);
        check_idle_outputs("reset_held");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("idle_after_abort");
        end
        fill_random();
        compute_reference();
        apply_stimulus(1, 4, 1'b1, -1);
        check_result_matrix("restart_after_abort");
    endtask

    task automatic test_random();
        for (int n = 0; n < 2; n++) begin
            fill_random();
            compute_reference();
            clear_result();
            apply_stimulus(1, 4, n[0], -1);
            check_result_matrix("random");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_identity();
        test_constant();
        test_signed();
        test_ack_hold();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
